lsu: RTL



---
 rtl/lsu_if.sv | 24 ++
 rtl/lsu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_if.sv
// lsu_if: data-bus request/response bundle between the load/store unit and memory.
// Latency: none, wires only.
// Backpressure: the requester holds bus_req and its payload until bus_ack.
interface lsu_if #(
  parameter int XLEN = 32
);
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [3:0]      bus_wstrb;
  logic            bus_ack;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu.sv
// lsu: load/store unit on the execution unit's memory interface; formats stores, extends loads.
// Latency: zero-wait access retires in its request cycle, rd_data registered 1 posedge later.
// Backpressure: stall held while bus_ack is outstanding; TIMEOUT (0 = off) aborts with a fault pulse.
// Optional: LSU_MISALIGN_TRAP_EN faults misaligned half/word accesses instead of aligning them down.
module lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] reg_out,
  input  logic            mm_we,
  input  logic            mm_re,
  input  logic            passthrough,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] rd_data,
  output logic            stall,
  output logic            fault,
  lsu_if.master           bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [3:0]      wstrb_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [CW-1:0]   cnt_q;
  logic            fault_q;

  logic            req_in, misalign_in;
  logic [XLEN-1:0] wdata_in;
  logic [3:0]      wstrb_in;

  logic            req_o, we_o;
  logic [XLEN-1:0] addr_o, wdata_o;
  logic [3:0]      wstrb_o;
  logic            load_done, abort, mis;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_lane;

  assign req_in = mm_re | mm_we;

`ifdef LSU_MISALIGN_TRAP_EN
  // Size decode differs for loads (funct3[2] is the unsigned flag) and stores (only 000/001 are narrow).
  logic is_byte, is_half;
  assign is_byte     = mm_we ? (funct3 == 3'b000) : (funct3[1:0] == 2'b00);
  assign is_half     = mm_we ? (funct3 == 3'b001) : (funct3[1:0] == 2'b01);
  assign misalign_in = (is_half & result[0]) | (~is_byte & ~is_half & (result[1:0] != 2'b00));
`else
  assign misalign_in = 1'b0;
`endif

  // Lane-replicate store data and build byte strobes; loads never write.
  always_comb begin
    wdata_in = reg_out;
    wstrb_in = 4'b1111;
    case (funct3)
      3'b000: begin
        wdata_in = {4{reg_out[7:0]}};
        wstrb_in = 4'b0001 << result[1:0];
      end
      3'b001: begin
        wdata_in = {2{reg_out[15:0]}};
        wstrb_in = result[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!mm_we) wstrb_in = 4'b0000;
  end

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] w,
                                               input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lane, 3'b000});
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{(XLEN-8){b[7]}}, b};
      3'b001:  load_ext = {{(XLEN-16){h[15]}}, h};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, b};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, h};
      default: load_ext = w;
    endcase
  endfunction

  // Next state, bus drive and stall: IDLE drives the bus from the inputs, BUSY from the holding registers.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    req_o     = 1'b0;
    we_o      = mm_we;
    addr_o    = {result[XLEN-1:2], 2'b00};
    wdata_o   = wdata_in;
    wstrb_o   = wstrb_in;
    load_done = 1'b0;
    abort     = 1'b0;
    mis       = 1'b0;
    ld_f3     = funct3;
    ld_lane   = result[1:0];
    case (state_q)
      IDLE: begin
        if (req_in) begin
          if (misalign_in) begin
            mis = 1'b1;
          end else begin
            req_o = 1'b1;
            if (bus.bus_ack) begin
              load_done = ~mm_we;
            end else begin
              stall   = 1'b1;
              state_d = BUSY;
            end
          end
        end
      end
      BUSY: begin
        req_o   = 1'b1;
        we_o    = we_q;
        addr_o  = {addr_q[XLEN-1:2], 2'b00};
        wdata_o = wdata_q;
        wstrb_o = wstrb_q;
        ld_f3   = funct3_q;
        ld_lane = addr_q[1:0];
        if (bus.bus_ack) begin
          load_done = ~we_q;
          state_d   = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          // Abort cycle: request still visible, execution unit released.
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) begin
      req_o = 1'b0;
      stall = 1'b0;
    end
  end

  // State, wait counter, fault pulse and writeback register; rd_data only moves when not stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_data <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= abort | mis;
      cnt_q   <= (state_q == BUSY && stall) ? cnt_q + 1'b1 : '0;
      if (!stall) begin
        if (abort | mis)     rd_data <= '0;
        else if (passthrough) rd_data <= result;
        else if (load_done)   rd_data <= load_ext(bus.bus_rdata, ld_f3, ld_lane);
        else                  rd_data <= '0;
      end
    end
  end

  // Capture the access while idle so the bus payload stays stable through wait states.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      addr_q   <= result;
      wdata_q  <= wdata_in;
      wstrb_q  <= wstrb_in;
      we_q     <= mm_we;
      funct3_q <= funct3;
    end
  end

  assign fault         = fault_q & rst_n;
  assign bus.bus_req   = req_o;
  assign bus.bus_we    = we_o;
  assign bus.bus_addr  = addr_o;
  assign bus.bus_wdata = wdata_o;
  assign bus.bus_wstrb = wstrb_o;

endmodule
